// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions used by IF, decode and hazard logic.
//   fetch_state_t : IF control states (BOOT, RUN, HALT)
//   NOP_INSTR     : bubble word, addi x0,x0,0
//   RESET_PC      : first fetch address after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   i_load             : capture i_instr / i_pc / i_pc_plus4, mark valid
//   i_flush            : load a bubble (valid=0, NOP); PC fields hold
//   i_instr, i_pc,
//   i_pc_plus4         : values captured on load
//   o_valid, o_instr,
//   o_pc, o_pc_plus4   : registered IF/ID contents
// Flush has priority over load; neither asserted means hold.
module if_id_reg #(
  parameter int unsigned      ADDR_WIDTH  = 32,
  parameter int unsigned      INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR[INSTR_WIDTH-1:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic                   i_flush,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

  logic                   r_valid;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_pc_plus4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the RV32I core: PC register, next-PC selection, fetch FSM.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   imem_addr     : instruction memory byte address (= PC_F)
//   imem_rdata    : instruction word, combinational from memory
//   id_ready      : decode accepts IF/ID this cycle (0 = hold)
//   redirect      : EX taken branch/jump, redirect_pc is the target
//   halt_req      : stop fetching
//   if_valid, if_instr, if_pc, if_pc_plus4 : IF/ID register contents
//   misalign_err  : sticky, a redirect target had nonzero low bits
module fetch_stage #(
  parameter int unsigned             ADDR_WIDTH  = 32,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = fetch_pkg::RESET_PC[ADDR_WIDTH-1:0],
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = fetch_pkg::NOP_INSTR[INSTR_WIDTH-1:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   id_ready,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt_req,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus4,
  output logic                   misalign_err
);

  import fetch_pkg::*;

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_redirect_aligned;
  logic                  r_misalign;
  logic                  w_misalign_set;
  logic                  w_load;
  logic                  w_flush;

  // Wraps modulo 2^ADDR_WIDTH by construction.
  assign w_pc_plus4         = r_pc + ADDR_WIDTH'(4);
  assign w_redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // Redirect is honoured in every state, so the misalignment flag only
  // depends on the request itself.
  assign w_misalign_set = redirect && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      BOOT: begin
        // IF/ID is already a bubble here; flushing keeps it that way.
        w_state_nxt = RUN;
        if (redirect) begin
          w_pc_nxt = w_redirect_aligned;
          w_flush  = 1'b1;
        end
      end
      RUN: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_aligned;
          w_flush  = 1'b1;
        end else if (id_ready) begin
          w_load   = 1'b1;
          w_pc_nxt = w_pc_plus4;
          if (halt_req) w_state_nxt = HALT;
        end
      end
      HALT: begin
        if (redirect) begin
          w_pc_nxt    = w_redirect_aligned;
          w_flush     = 1'b1;
          w_state_nxt = RUN;
        end else if (id_ready) begin
          w_flush = 1'b1;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_misalign_set) r_misalign <= 1'b1;
    end
  end

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_flush   (w_flush),
    .i_instr   (imem_rdata),
    .i_pc      (r_pc),
    .i_pc_plus4(w_pc_plus4),
    .o_valid   (if_valid),
    .o_instr   (if_instr),
    .o_pc      (if_pc),
    .o_pc_plus4(if_pc_plus4)
  );

  assign imem_addr    = r_pc;
  assign misalign_err = r_misalign;

endmodule
